// File: rtl/master_sequencer.sv
// Top-level master FSM: conditions BTNL/BTNC/BTNR, sequences IDLE/PLAY/PAUSE/WIN/LOSE, counts wins.
// Optional feature macro MASTER_AUTO_RETURN_EN: frame-timed return from WIN/LOSE to IDLE.
module master_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned RETURN_FRAMES   = 180
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTNL,
  input  logic       BTNC,
  input  logic       BTNR,
  input  logic       VS,
  input  logic       WIN_EVENT,
  input  logic       LOSE_EVENT,
  output logic [2:0] MASTER_STATE,
  output logic       GAME_EN,
  output logic       GAME_RESTART,
  output logic [3:0] ROUNDS_WON
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    PLAY  = 3'b001,
    PAUSE = 3'b010,
    WIN   = 3'b011,
    LOSE  = 3'b100
  } state_t;

  state_t        state, state_next;
  logic          restart_next;
  logic          game_en_next;
  logic          win_inc;
  logic          expire;

  // Button index: 0 = left, 1 = centre, 2 = right
  logic [2:0]    raw;
  logic [2:0]    sync1, sync2, deb, deb_d;
  logic [CW-1:0] cnt [3];
  logic [2:0]    press;

  assign raw   = {BTNR, BTNC, BTNL};
  assign press = deb & ~deb_d;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef MASTER_AUTO_RETURN_EN
  localparam int unsigned FW = $clog2(RETURN_FRAMES + 1);

  logic          vs_q;
  logic          frame_tick;
  logic [FW-1:0] frame_cnt;

  assign frame_tick = vs_q & ~VS;
  // Expiry fires on the edge that samples the final tick, so the count never needs to hold RETURN_FRAMES
  assign expire     = frame_tick && (frame_cnt == FW'(RETURN_FRAMES - 1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      vs_q      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      vs_q <= VS;
      if (state != WIN && state != LOSE) begin
        frame_cnt <= '0;
      end else if (frame_tick) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_vs;
  assign unused_vs = VS;
  assign expire    = 1'b0;
`endif

  always_comb begin
    state_next   = state;
    restart_next = 1'b0;
    win_inc      = 1'b0;
    case (state)
      IDLE: begin
        if (press[1]) begin
          state_next   = PLAY;
          restart_next = 1'b1;
        end
      end
      PLAY: begin
        if (LOSE_EVENT) begin
          state_next = LOSE;
        end else if (WIN_EVENT) begin
          state_next = WIN;
          win_inc    = 1'b1;
        end else if (press[1]) begin
          state_next = PAUSE;
        end
      end
      PAUSE: begin
        if (press[1]) begin
          state_next = PLAY;
        end else if (press[0]) begin
          state_next   = PLAY;
          restart_next = 1'b1;
        end else if (press[2]) begin
          state_next = IDLE;
        end
      end
      WIN, LOSE: begin
        if (press[1] || expire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    game_en_next = (state_next == PLAY);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state        <= IDLE;
      GAME_EN      <= 1'b0;
      GAME_RESTART <= 1'b0;
      ROUNDS_WON   <= '0;
    end else begin
      state        <= state_next;
      GAME_EN      <= game_en_next;
      GAME_RESTART <= restart_next;
      if (win_inc && ROUNDS_WON != 4'd15) ROUNDS_WON <= ROUNDS_WON + 4'd1;
    end
  end

  assign MASTER_STATE = state;

endmodule

// File: tb/tb_master_sequencer.sv
// Directed self-checking bench for master_sequencer (DEBOUNCE_CYCLES=4, RETURN_FRAMES=3).
module tb_master_sequencer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       BTNL = 1'b0, BTNC = 1'b0, BTNR = 1'b0;
  logic       VS = 1'b1;
  logic       WIN_EVENT = 1'b0, LOSE_EVENT = 1'b0;
  logic [2:0] MASTER_STATE;
  logic       GAME_EN, GAME_RESTART;
  logic [3:0] ROUNDS_WON;

  int checks = 0;
  int errors = 0;
  int rs;
  logic [7:0] exp_rw;

  master_sequencer #(.DEBOUNCE_CYCLES(4), .RETURN_FRAMES(3)) dut (
    .CLK(CLK), .RESET(RESET), .BTNL(BTNL), .BTNC(BTNC), .BTNR(BTNR), .VS(VS),
    .WIN_EVENT(WIN_EVENT), .LOSE_EVENT(LOSE_EVENT), .MASTER_STATE(MASTER_STATE),
    .GAME_EN(GAME_EN), .GAME_RESTART(GAME_RESTART), .ROUNDS_WON(ROUNDS_WON)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] st, input logic [7:0] en,
                         input logic [7:0] rst, input logic [7:0] rw);
    chk({tag, ".state"},   8'(MASTER_STATE), st);
    chk({tag, ".en"},      8'(GAME_EN),      en);
    chk({tag, ".restart"}, 8'(GAME_RESTART), rst);
    chk({tag, ".rounds"},  8'(ROUNDS_WON),   rw);
  endtask

  // Hold a button long enough for one accepted press, then release and let it settle
  task automatic press(input int which, output int restarts);
    restarts = 0;
    case (which)
      0: BTNL = 1'b1;
      1: BTNC = 1'b1;
      default: BTNR = 1'b1;
    endcase
    repeat (10) begin step(); if (GAME_RESTART) restarts++; end
    BTNL = 1'b0; BTNC = 1'b0; BTNR = 1'b0;
    repeat (8) begin step(); if (GAME_RESTART) restarts++; end
  endtask

  task automatic pulse_win(input logic w, input logic l);
    WIN_EVENT = w; LOSE_EVENT = l;
    step();
    WIN_EVENT = 1'b0; LOSE_EVENT = 1'b0;
  endtask

  task automatic vs_fall();
    VS = 1'b0;
    step();
    VS = 1'b1;
    step();
    step();
  endtask

  initial begin
    // Reset
    #2;
    repeat (3) step();
    chk_all("rst_low", 8'd0, 8'd0, 8'd0, 8'd0);
    RESET = 1'b1;
    step();
    chk_all("rst_rel", 8'd0, 8'd0, 8'd0, 8'd0);

    // Short bounce: three sampled highs never qualify
    BTNC = 1'b1;
    repeat (3) step();
    BTNC = 1'b0;
    repeat (8) step();
    chk("bounce.state", 8'(MASTER_STATE), 8'd0);

    // Start: state changes exactly 6 edges after the first sampled high
    BTNC = 1'b1;
    repeat (6) step();
    chk("start.pre", 8'(MASTER_STATE), 8'd0);
    step();
    chk_all("start", 8'd1, 8'd1, 8'd1, 8'd0);
    step();
    chk("start.restart_off", 8'(GAME_RESTART), 8'd0);
    repeat (2) step();
    BTNC = 1'b0;
    repeat (8) step();
    chk("start.hold_once", 8'(MASTER_STATE), 8'd1);

    // Pause / restart / resume / quit
    press(1, rs);
    chk_all("pause", 8'd2, 8'd0, 8'd0, 8'd0);
    press(0, rs);
    chk_all("restart", 8'd1, 8'd1, 8'd0, 8'd0);
    chk("restart.pulses", 8'(rs), 8'd1);
    press(1, rs);
    chk("pause2", 8'(MASTER_STATE), 8'd2);
    press(1, rs);
    chk("resume", 8'(MASTER_STATE), 8'd1);
    chk("resume.pulses", 8'(rs), 8'd0);
    press(1, rs);
    press(2, rs);
    chk_all("quit", 8'd0, 8'd0, 8'd0, 8'd0);

    // Events ignored in IDLE
    pulse_win(1'b1, 1'b0);
    step();
    chk_all("idle_win", 8'd0, 8'd0, 8'd0, 8'd0);

    // Simultaneous WIN/LOSE -> LOSE, no increment; state visible right after sampling edge
    press(1, rs);
    chk("play2", 8'(MASTER_STATE), 8'd1);
    pulse_win(1'b1, 1'b1);
    chk_all("both", 8'd4, 8'd0, 8'd0, 8'd0);
    vs_fall();
    vs_fall();
    chk("lose.2frames", 8'(MASTER_STATE), 8'd4);
    press(1, rs);
    chk("lose.exit", 8'(MASTER_STATE), 8'd0);

    // Win and frame-timed auto-return
    press(1, rs);
    pulse_win(1'b1, 1'b0);
    chk_all("win", 8'd3, 8'd0, 8'd0, 8'd1);
    vs_fall();
    vs_fall();
    chk("win.2frames", 8'(MASTER_STATE), 8'd3);
    VS = 1'b0;
    step();
    VS = 1'b1;
`ifdef MASTER_AUTO_RETURN_EN
    chk("auto_return", 8'(MASTER_STATE), 8'd0);
`else
    chk("no_auto_return", 8'(MASTER_STATE), 8'd3);
    press(1, rs);
    chk("win.exit", 8'(MASTER_STATE), 8'd0);
`endif
    step();

    // 16 further wins: count saturates at 15; leave the last round in WIN
    exp_rw = 8'd1;
    for (int i = 0; i < 16; i++) begin
      press(1, rs);
      chk("sat.play", 8'(MASTER_STATE), 8'd1);
      pulse_win(1'b1, 1'b0);
      exp_rw = (exp_rw == 8'd15) ? 8'd15 : exp_rw + 8'd1;
      chk("sat.state", 8'(MASTER_STATE), 8'd3);
      chk("sat.rounds", 8'(ROUNDS_WON), exp_rw);
      if (i < 15) press(1, rs);
    end

    // Async reset mid-WIN and mid-debounce, away from any clock edge
    BTNC = 1'b1;
    repeat (2) step();
    #2;
    RESET = 1'b0;
    #1;
    chk_all("async_rst", 8'd0, 8'd0, 8'd0, 8'd0);
    BTNC = 1'b0;
    repeat (2) step();
    RESET = 1'b1;
    repeat (10) step();
    chk_all("post_rst", 8'd0, 8'd0, 8'd0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
